cache_axi_rd_arbiter: RTL
=========================

// Module: cache_axi_rd_arbiter
// PURPOSE
//  Shares the single AXI read channel (AR/R) between the icache and dcache refill ports.
//  Arbitrates each requester's rd_req/rd_type/rd_addr with round-robin and a registered AR stage.
//  Routes R beats back to the owner by rid; allows one outstanding read per cache.
//  Sits between the two cache instances and the AXI read side of the SRAM/AXI bridge.
// PARAMETERS
//  ICACHE_ID   4'd0  arid/rid value tagging icache transactions
//  DCACHE_ID   4'd1  arid/rid value tagging dcache transactions
//  LINE_WORDS  4     32-bit words per cache line; line refill uses arlen = LINE_WORDS-1
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  reset          in   1   asynchronous, active-high reset
//  i_rd_req       in   1   icache read request
//  i_rd_type      in   3   3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 cache line
//  i_rd_addr      in   32  icache read address
//  i_rd_rdy       out  1   icache request accepted this cycle (when i_rd_req=1)
//  i_ret_valid    out  1   icache return beat valid
//  i_ret_last     out  1   last icache return beat
//  i_ret_data     out  32  icache return data
//  d_rd_req/d_rd_type/d_rd_addr/d_rd_rdy/d_ret_valid/d_ret_last/d_ret_data: same for dcache
//  arid           out  4   AXI read ID
//  araddr         out  32  AXI read address
//  arlen          out  8   AXI burst length - 1
//  arsize         out  3   AXI beat size (log2 bytes)
//  arvalid        out  1   AXI AR valid
//  arready        in   1   AXI AR ready
//  rid            in   4   AXI R ID
//  rdata          in   32  AXI R data
//  rlast          in   1   AXI R last
//  rvalid         in   1   AXI R valid
//  rready         out  1   AXI R ready; tied 1 (caches always accept return beats)
//  rid_err        out  1   sticky: R beat seen with rid not ICACHE_ID/DCACHE_ID
// BEHAVIOUR
//  Reset: arvalid=0, arid=0, araddr=0, arlen=0, arsize=0, rid_err=0; i_busy=d_busy=0;
//   rr_ptr=dcache, so dcache wins the first conflict. rready=1 during reset and after.
//  AR FSM:
//   IDLE  ->  AR_WAIT when a request is granted.
//   AR_WAIT -> IDLE on arvalid&&arready; arvalid=1 throughout AR_WAIT.
//   AR fields stay stable while arvalid=1.
//  Eligibility: requester X is eligible when X_rd_req=1, X_busy=0 and FSM=IDLE.
//  Grant:
//   Only one eligible -> it is granted.
//   Both eligible -> the one pointed to by rr_ptr is granted; rr_ptr flips to the other after each grant.
//  X_rd_rdy=1 only in the granted cycle (combinational from registered state and X_rd_req).
//  Grant latches ID/addr/len/size into the AR registers; arvalid rises the next cycle (1-cycle latency).
//  Earliest back-to-back AR: the cycle after the arready handshake.
//  Size encoding:
//   type 3'b100 -> arlen=LINE_WORDS-1, arsize=3'd2.
//   Otherwise   -> arlen=0, arsize={1'b0,type[1:0]}; araddr passed unmodified.
//   Any other type value is treated as a word read.
//  X_busy: set on the AR handshake of X's transaction; cleared on rvalid&&rlast&&rid==X_ID.
//  Return path (combinational):
//   X_ret_valid = rvalid && rid==X_ID.
//   X_ret_last  = X_ret_valid && rlast.
//   X_ret_data  = rdata.
//   Beats of either ID may interleave.
//  Boundaries:
//   - rlast for X and a new X_rd_req in the same cycle: not accepted; busy clears at the edge, so accept is next cycle at earliest.
//   - AR handshake for X and an X R beat in the same cycle cannot occur: X has one outstanding read.
//   - arready held high while idle: no effect.
//   - rvalid with an unknown rid: beat dropped, rid_err set until reset.
//   - reset mid-burst or mid-AR: all state returns to reset values and in-flight beats are discarded.
//     The bench must not return stale beats after reset.
//  Out of scope: write channel ordering; the bridge enforces read-after-write.
// TESTING
//  1. icache line req at 0x1c000040, arready=1 -> i_rd_rdy same cycle; next cycle arvalid=1, arid=0, arlen=3, arsize=2; 4 beats rid=0 -> i_ret_valid x4, i_ret_last on 4th.
//  2. i_rd_req and d_rd_req both asserted after reset -> dcache granted first (arid=1); icache granted in the cycle after the dcache AR handshake.
//  3. dcache byte read at 0x1faf0003 (type 000) -> arlen=0, arsize=0, araddr=0x1faf0003; single beat rid=1, rlast=1 -> d_ret_last=1.
//  4. Interleave rid=0 and rid=1 beats with rvalid continuously high -> each beat routed only to its owner; busy flags clear on their own rlast.
//  5. arready held 0 for 5 cycles -> arvalid stays 1 with stable arid/araddr/arlen; no new rd_rdy until the handshake.
//  6. rvalid with rid=4'd7 -> no ret_valid on either port, rid_err=1; assert reset mid icache burst -> arvalid=0, i_busy=0, rid_err=0.

Source files
------------

// File: rtl/cache_axi_rd_arbiter.sv
// Purpose: shares one AXI read channel (AR/R) between icache and dcache refill ports, round-robin on conflict.
// Latency: rd_rdy is combinational in the grant cycle and arvalid rises one cycle later; R beats are routed combinationally by rid.
// Backpressure: AR fields are held while arready is low; each cache has one read outstanding; rready is always 1.
module cache_axi_rd_arbiter #(
    parameter logic [3:0] ICACHE_ID  = 4'd0,
    parameter logic [3:0] DCACHE_ID  = 4'd1,
    parameter int         LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_rd_req,
    input  logic [2:0]  i_rd_type,
    input  logic [31:0] i_rd_addr,
    output logic        i_rd_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_ret_data,

    input  logic        d_rd_req,
    input  logic [2:0]  d_rd_type,
    input  logic [31:0] d_rd_addr,
    output logic        d_rd_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_ret_data,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rid_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        AR_WAIT = 1'b1
    } ar_state_t;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
    } ar_shape_t;

    ar_state_t state;
    logic      i_busy;
    logic      d_busy;
    logic      rr_ptr;      // 1: dcache wins the next conflict

    logic      i_elig;
    logic      d_elig;
    logic      grant_i;
    logic      grant_d;
    logic      ar_hs;

    logic [3:0]  nxt_id;
    logic [31:0] nxt_addr;
    ar_shape_t   nxt_shape;

    // Line refills burst a whole line; unrecognised types fall back to a word read.
    function automatic ar_shape_t shape_of(input logic [2:0] rd_type);
        ar_shape_t s;
        case (rd_type)
            3'b100: begin
                s.len  = 8'(LINE_WORDS - 1);
                s.size = 3'd2;
            end
            3'b000, 3'b001, 3'b010: begin
                s.len  = 8'd0;
                s.size = {1'b0, rd_type[1:0]};
            end
            default: begin
                s.len  = 8'd0;
                s.size = 3'd2;
            end
        endcase
        return s;
    endfunction

    assign i_elig  = i_rd_req && !i_busy && (state == IDLE);
    assign d_elig  = d_rd_req && !d_busy && (state == IDLE);
    assign grant_d = d_elig && (!i_elig || rr_ptr);
    assign grant_i = i_elig && (!d_elig || !rr_ptr);
    assign ar_hs   = arvalid && arready;

    assign i_rd_rdy = grant_i;
    assign d_rd_rdy = grant_d;

    always_comb begin
        nxt_id    = ICACHE_ID;
        nxt_addr  = i_rd_addr;
        nxt_shape = shape_of(i_rd_type);
        if (grant_d) begin
            nxt_id    = DCACHE_ID;
            nxt_addr  = d_rd_addr;
            nxt_shape = shape_of(d_rd_type);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            arvalid <= 1'b0;
            arid    <= 4'd0;
            araddr  <= 32'd0;
            arlen   <= 8'd0;
            arsize  <= 3'd0;
            rr_ptr  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        state   <= AR_WAIT;
                        arvalid <= 1'b1;
                        arid    <= nxt_id;
                        araddr  <= nxt_addr;
                        arlen   <= nxt_shape.len;
                        arsize  <= nxt_shape.size;
                        rr_ptr  <= grant_i;
                    end
                end
                AR_WAIT: begin
                    if (arready) begin
                        state   <= IDLE;
                        arvalid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    arvalid <= 1'b0;
                end
            endcase
        end
    end

    // A cache is busy from its AR handshake until the last beat tagged with its ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_busy  <= 1'b0;
            d_busy  <= 1'b0;
            rid_err <= 1'b0;
        end else begin
            if (ar_hs && arid == ICACHE_ID)
                i_busy <= 1'b1;
            else if (rvalid && rlast && rid == ICACHE_ID)
                i_busy <= 1'b0;

            if (ar_hs && arid == DCACHE_ID)
                d_busy <= 1'b1;
            else if (rvalid && rlast && rid == DCACHE_ID)
                d_busy <= 1'b0;

            if (rvalid && rid != ICACHE_ID && rid != DCACHE_ID)
                rid_err <= 1'b1;
        end
    end

    assign rready      = 1'b1;
    assign i_ret_valid = rvalid && (rid == ICACHE_ID);
    assign i_ret_last  = i_ret_valid && rlast;
    assign i_ret_data  = rdata;
    assign d_ret_valid = rvalid && (rid == DCACHE_ID);
    assign d_ret_last  = d_ret_valid && rlast;
    assign d_ret_data  = rdata;

endmodule
